// File: rtl/ramulator_tg_pkg.sv
// Shared types and helpers for the ramulator traffic generator.
package ramulator_tg_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INIT,
        ISSUE,
        DRAIN,
        DONE
    } tg_state_e;

    typedef logic [CNT_W-1:0] cnt_t;

    // Slots written in pass 0 read back the pattern; all others echo the address.
    function automatic logic [63:0] tg_expected(
        input logic [63:0] addr,
        input logic [31:0] k,
        input int unsigned wr_every,
        input logic        two_pass,
        input logic [63:0] pattern
    );
        if (two_pass && (k % wr_every) == 32'd0)
            return addr ^ pattern;
        return addr;
    endfunction

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/ramulator_tg_cam.sv
// Outstanding-read CAM: lowest-free allocation, lowest-match free.
module ramulator_tg_cam #(
    parameter int  ADDR_W = 64,
    parameter int  DEPTH  = 64,
    parameter int  K_W    = 8,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              alloc,
    input  logic [ADDR_W-1:0] alloc_addr,
    input  logic [K_W-1:0]    alloc_k,
    input  logic              lookup,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [K_W-1:0]    hit_k,
    output logic              full,
    output logic [CW-1:0]     count
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]  vld;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [K_W-1:0]    k_q    [DEPTH];
    logic [IW-1:0]     free_idx;
    logic [IW-1:0]     hit_idx;
    logic              free_ok;
    logic              match;
    logic              do_alloc;

    // Scan high-to-low so the lowest index wins both searches.
    always_comb begin
        free_ok  = 1'b0;
        free_idx = '0;
        match    = 1'b0;
        hit_idx  = '0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (!vld[j]) begin
                free_ok  = 1'b1;
                free_idx = IW'(j);
            end
            if (vld[j] && addr_q[j] == lookup_addr) begin
                match   = 1'b1;
                hit_idx = IW'(j);
            end
        end
    end

    assign hit      = lookup && match;
    assign hit_k    = k_q[hit_idx];
    assign do_alloc = alloc && free_ok;
    assign full     = (count == CW'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld   <= '0;
            count <= '0;
        end else if (clr) begin
            vld   <= '0;
            count <= '0;
        end else begin
            if (hit)
                vld[hit_idx] <= 1'b0;
            if (do_alloc)
                vld[free_idx] <= 1'b1;
            count <= count + CW'(do_alloc) - CW'(hit);
        end
    end

    always_ff @(posedge clk) begin
        if (do_alloc) begin
            addr_q[free_idx] <= alloc_addr;
            k_q[free_idx]    <= alloc_k;
        end
    end

endmodule

// File: rtl/ramulator_traffic_gen.sv
// Request generator/checker driving the ramulator wrapper req/resp port.
module ramulator_traffic_gen
    import ramulator_tg_pkg::*;
#(
    parameter int          ADDR_W       = 64,
    parameter int          DATA_W       = 64,
    parameter int          NUM_REQS     = 128,
    parameter logic [63:0] BASE_ADDR    = 64'd0,
    parameter logic [63:0] ADDR_STRIDE  = 64'd64,
    parameter int          WR_EVERY     = 4,
    parameter logic [63:0] WR_PATTERN   = 64'hDEADBEEFCAFEBABE,
    parameter int          MAX_INFLIGHT = 64,
    parameter int          NUM_PASSES   = 2,
    parameter int          TIMEOUT_CYC  = 100000,
    parameter logic [31:0] SRC_ID       = 32'd0,
    localparam int         IF_W         = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              init_done,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    output logic              req_type,
    output logic [31:0]       req_source_id,
    output logic [DATA_W-1:0] req_data,
    input  logic              req_ready,
    input  logic              resp_valid,
    input  logic [ADDR_W-1:0] resp_addr,
    input  logic [DATA_W-1:0] resp_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  accepted_cnt,
    output logic [CNT_W-1:0]  rejected_cnt,
    output logic [CNT_W-1:0]  reads_done,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [CNT_W-1:0]  unmatched_cnt,
    output logic [IF_W-1:0]   inflight
);

    localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int WP_W  = (WR_EVERY > 1) ? $clog2(WR_EVERY) : 1;
    localparam int EXP_READS = NUM_REQS - (NUM_REQS + WR_EVERY - 1) / WR_EVERY
                             + ((NUM_PASSES == 2) ? NUM_REQS : 0);

    tg_state_e         state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [WP_W-1:0]   wp_q;
    logic              pass_q;
    logic [ADDR_W-1:0] addr_q;
    cnt_t              drain_q;
    logic              timeout_q;
    cnt_t              acc_q, rej_q, rd_q, mis_q, unm_q;

    logic              is_wr, xfer, last, rsp_act, clr;
    logic              cam_hit, cam_full;
    logic [IDX_W-1:0]  cam_k;
    logic [63:0]       exp_full, wdat_full;
    logic [DATA_W-1:0] exp_data;

    assign is_wr   = !pass_q && (wp_q == '0);
    assign xfer    = req_valid && req_ready;
    assign last    = (idx_q == IDX_W'(NUM_REQS - 1)) && (NUM_PASSES == 1 || pass_q);
    assign rsp_act = resp_valid && (state_q == ISSUE || state_q == DRAIN);
    assign clr     = start && (state_q == IDLE || state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (start) state_d = WAIT_INIT;
            WAIT_INIT: if (init_done) state_d = ISSUE;
            ISSUE:     if (xfer && last) state_d = DRAIN;
            DRAIN:     if (inflight == '0 || drain_q == cnt_t'(TIMEOUT_CYC - 1))
                           state_d = DONE;
            DONE:      if (start) state_d = WAIT_INIT;
            default:   state_d = IDLE;
        endcase
    end

    // A read is held back only while the CAM is full; writes always go.
    always_comb begin
        busy      = (state_q != IDLE) && (state_q != DONE);
        done      = (state_q == DONE);
        req_valid = (state_q == ISSUE) && (is_wr || !cam_full);
    end

    assign wdat_full     = 64'(addr_q) ^ WR_PATTERN;
    assign req_addr      = req_valid ? addr_q : '0;
    assign req_type      = req_valid && is_wr;
    assign req_data      = (req_valid && is_wr) ? wdat_full[DATA_W-1:0] : '0;
    assign req_source_id = SRC_ID;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            wp_q   <= '0;
            pass_q <= 1'b0;
            addr_q <= BASE_ADDR[ADDR_W-1:0];
        end else if (clr) begin
            idx_q  <= '0;
            wp_q   <= '0;
            pass_q <= 1'b0;
            addr_q <= BASE_ADDR[ADDR_W-1:0];
        end else if (xfer) begin
            if (idx_q == IDX_W'(NUM_REQS - 1)) begin
                idx_q  <= '0;
                wp_q   <= '0;
                pass_q <= !pass_q;
                addr_q <= BASE_ADDR[ADDR_W-1:0];
            end else begin
                idx_q  <= idx_q + IDX_W'(1);
                wp_q   <= (wp_q == WP_W'(WR_EVERY - 1)) ? '0 : wp_q + WP_W'(1);
                addr_q <= addr_q + ADDR_STRIDE[ADDR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            drain_q <= (state_q == DRAIN) ? sat_inc(drain_q) : '0;
            if (clr)
                timeout_q <= 1'b0;
            else if (state_q == DRAIN && inflight != '0
                     && drain_q == cnt_t'(TIMEOUT_CYC - 1))
                timeout_q <= 1'b1;
        end
    end

    ramulator_tg_cam #(
        .ADDR_W (ADDR_W),
        .DEPTH  (MAX_INFLIGHT),
        .K_W    (IDX_W)
    ) u_cam (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .alloc       (xfer && !is_wr),
        .alloc_addr  (addr_q),
        .alloc_k     (idx_q),
        .lookup      (rsp_act),
        .lookup_addr (resp_addr),
        .hit         (cam_hit),
        .hit_k       (cam_k),
        .full        (cam_full),
        .count       (inflight)
    );

    assign exp_full = tg_expected(64'(resp_addr), 32'(cam_k), WR_EVERY,
                                  NUM_PASSES == 2, WR_PATTERN);
    assign exp_data = exp_full[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            rej_q <= '0;
            rd_q  <= '0;
            mis_q <= '0;
            unm_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
            rej_q <= '0;
            rd_q  <= '0;
            mis_q <= '0;
            unm_q <= '0;
        end else begin
            if (xfer)
                acc_q <= sat_inc(acc_q);
            if (req_valid && !req_ready)
                rej_q <= sat_inc(rej_q);
            if (rsp_act) begin
                if (cam_hit) begin
                    rd_q <= sat_inc(rd_q);
                    if (resp_data != exp_data)
                        mis_q <= sat_inc(mis_q);
                end else begin
                    unm_q <= sat_inc(unm_q);
                end
            end
        end
    end

    assign timeout       = timeout_q;
    assign accepted_cnt  = acc_q;
    assign rejected_cnt  = rej_q;
    assign reads_done    = rd_q;
    assign mismatch_cnt  = mis_q;
    assign unmatched_cnt = unm_q;
    assign pass = done && !timeout_q && mis_q == '0 && unm_q == '0
               && rd_q == cnt_t'(EXP_READS);

endmodule

// File: tb/tb_ramulator_traffic_gen.sv
// Scoreboard bench: golden request stream, memory model, two DUT configs.
module tb_ramulator_traffic_gen;

    localparam int          N   = 128;
    localparam logic [63:0] PAT = 64'hDEADBEEFCAFEBABE;

    typedef struct {
        logic [63:0] addr;
        logic        typ;
        logic [63:0] data;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, init_done, req_ready, resp_valid;
    logic [63:0] resp_addr, resp_data;
    logic        req_valid, req_type, busy, done, pass, timeout;
    logic [63:0] req_addr, req_data;
    logic [31:0] req_source_id;
    logic [31:0] accepted_cnt, rejected_cnt, reads_done, mismatch_cnt, unmatched_cnt;
    logic [6:0]  inflight;

    logic        start2, resp_valid2;
    logic [63:0] resp_addr2, resp_data2;
    logic        req_valid2, req_type2, busy2, done2, pass2, timeout2;
    logic [63:0] req_addr2, req_data2;
    logic [31:0] req_source_id2;
    logic [31:0] accepted2, rejected2, reads2, mismatch2, unmatched2;
    logic [2:0]  inflight2;

    ramulator_traffic_gen u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .init_done(init_done),
        .req_valid(req_valid), .req_addr(req_addr), .req_type(req_type),
        .req_source_id(req_source_id), .req_data(req_data),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_addr(resp_addr), .resp_data(resp_data),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .accepted_cnt(accepted_cnt), .rejected_cnt(rejected_cnt),
        .reads_done(reads_done), .mismatch_cnt(mismatch_cnt),
        .unmatched_cnt(unmatched_cnt), .inflight(inflight)
    );

    ramulator_traffic_gen #(
        .MAX_INFLIGHT(4), .TIMEOUT_CYC(1000)
    ) u_dut_to (
        .clk(clk), .rst_n(rst_n), .start(start2), .init_done(init_done),
        .req_valid(req_valid2), .req_addr(req_addr2), .req_type(req_type2),
        .req_source_id(req_source_id2), .req_data(req_data2),
        .req_ready(1'b1), .resp_valid(resp_valid2),
        .resp_addr(resp_addr2), .resp_data(resp_data2),
        .busy(busy2), .done(done2), .pass(pass2), .timeout(timeout2),
        .accepted_cnt(accepted2), .rejected_cnt(rejected2),
        .reads_done(reads2), .mismatch_cnt(mismatch2),
        .unmatched_cnt(unmatched2), .inflight(inflight2)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    req_t        sb_q[$];
    req_t        sb_e, held;
    logic        wait_q = 1'b0;
    logic [63:0] mem [logic [63:0]];
    logic [63:0] rd_q[$], bq[$], rd2_q[$];
    logic [63:0] a2;
    int          ready_mode = 0, resp_mode = 0, n40 = 0, idle_cyc = 0, cyc = 0, m;
    bit          corrupt = 0, dropped = 0;
    int          max_if2 = 0, thr_err = 0;

    task automatic push_exp();
        req_t r;
        sb_q.delete();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++) begin
                r.addr = 64'(i) * 64'd64;
                r.typ  = (p == 0) && (i % 4 == 0);
                r.data = r.typ ? (r.addr ^ PAT) : 64'd0;
                sb_q.push_back(r);
            end
    endtask

    task automatic give(input logic [63:0] a);
        resp_valid = 1'b1;
        resp_addr  = a;
        resp_data  = mem.exists(a) ? mem[a] : a;
        if (corrupt && a == 64'h40) begin
            n40++;
            if (n40 == 2)
                resp_data = resp_data ^ 64'd1;
        end
    endtask

    // Memory model for the default instance: in-order with gaps, or reversed batches.
    always @(posedge clk) begin
        #1;
        cyc++;
        idle_cyc++;
        req_ready  = (ready_mode == 0) || (cyc % 4 == 0);
        resp_valid = 1'b0;
        resp_addr  = '0;
        resp_data  = '0;
        if (rst_n) begin
            if (resp_mode == 1) begin
                if (bq.size() == 0 && (rd_q.size() >= 8
                        || (rd_q.size() > 0 && idle_cyc > 16))) begin
                    m = (rd_q.size() < 8) ? rd_q.size() : 8;
                    for (int j = 0; j < m; j++)
                        bq.push_front(rd_q.pop_front());
                end
                if (bq.size() > 0)
                    give(bq.pop_front());
            end else if (rd_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                give(rd_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && wait_q) begin
            chk("hold_valid", req_valid, 1);
            chk("hold_addr", req_addr, held.addr);
            chk("hold_type", req_type, held.typ);
            chk("hold_data", req_data, held.data);
        end
        wait_q    = rst_n && req_valid && !req_ready;
        held.addr = req_addr;
        held.typ  = req_type;
        held.data = req_data;
        if (rst_n && req_valid && req_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                sb_e = sb_q.pop_front();
                chk("req_addr", req_addr, sb_e.addr);
                chk("req_type", req_type, sb_e.typ);
                chk("req_data", req_data, sb_e.data);
            end
            if (req_type)
                mem[req_addr] = req_data;
            else begin
                rd_q.push_back(req_addr);
                idle_cyc = 0;
            end
        end
    end

    // Second instance: in-order, drops the first response to 0x80.
    always @(posedge clk) begin
        #1;
        resp_valid2 = 1'b0;
        resp_addr2  = '0;
        resp_data2  = '0;
        if (rst_n && rd2_q.size() > 0 && $urandom_range(0, 1) == 1) begin
            a2 = rd2_q.pop_front();
            if (a2 == 64'h80 && !dropped)
                dropped = 1;
            else begin
                resp_valid2 = 1'b1;
                resp_addr2  = a2;
                resp_data2  = mem.exists(a2) ? mem[a2] : a2;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (int'(inflight2) > max_if2)
                max_if2 = int'(inflight2);
            if (req_valid2 && !req_type2 && inflight2 == 3'd4)
                thr_err++;
            if (req_valid2) begin
                if (req_type2)
                    mem[req_addr2] = req_data2;
                else
                    rd2_q.push_back(req_addr2);
            end
        end
    end

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, done, 1);
    endtask

    task automatic run1(input int rm, input int sm, input bit cor, input string tag);
        ready_mode = rm;
        resp_mode  = sm;
        corrupt    = cor;
        n40        = 0;
        rd_q.delete();
        bq.delete();
        mem.delete();
        push_exp();
        init_done = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_acc_clr"}, accepted_cnt, 0);
        repeat (3) @(negedge clk);
        chk({tag, "_wait_init"}, req_valid, 0);
        init_done = 1'b1;
        wait_done(tag);
        chk({tag, "_sb_empty"}, sb_q.size(), 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        start2 = 1'b0;
        init_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", req_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_acc", accepted_cnt, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_addr", req_addr, 0);
        chk("rst_srcid", req_source_id, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run1(0, 0, 0, "t1");
        chk("t1_acc", accepted_cnt, 256);
        chk("t1_reads", reads_done, 224);
        chk("t1_mis", mismatch_cnt, 0);
        chk("t1_unm", unmatched_cnt, 0);
        chk("t1_rej", rejected_cnt, 0);
        chk("t1_pass", pass, 1);

        run1(1, 0, 0, "t2");
        chk("t2_rej_nz", rejected_cnt != 0, 1);
        chk("t2_acc", accepted_cnt, 256);
        chk("t2_pass", pass, 1);

        run1(0, 1, 0, "t3");
        chk("t3_reads", reads_done, 224);
        chk("t3_unm", unmatched_cnt, 0);
        chk("t3_pass", pass, 1);

        run1(0, 0, 1, "t4");
        chk("t4_mis", mismatch_cnt, 1);
        chk("t4_reads", reads_done, 224);
        chk("t4_pass", pass, 0);

        mem.delete();
        rd2_q.delete();
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("t5_done", done2, 1);
        chk("t5_timeout", timeout2, 1);
        chk("t5_pass", pass2, 0);
        chk("t5_acc", accepted2, 256);
        chk("t5_reads", reads2, 223);
        chk("t5_inflight", inflight2, 1);
        chk("t5_if_le4", max_if2 <= 4, 1);
        chk("t5_throttle", thr_err, 0);

        ready_mode = 0;
        resp_mode  = 0;
        corrupt    = 0;
        push_exp();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (accepted_cnt < 20 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_midrun", accepted_cnt >= 20 && !done, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", req_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_acc", accepted_cnt, 0);
        chk("t6_rst_inflight", inflight, 0);
        @(negedge clk);
        chk("t6_rst_valid2", req_valid, 0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run1(0, 0, 0, "t6");
        chk("t6_acc", accepted_cnt, 256);
        chk("t6_reads", reads_done, 224);
        chk("t6_pass", pass, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
